c1571_sd_arbiter: RTL and testbench

- Shares one MiSTer SD block port (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) between up to NDRIVES c1571_sd instances.
- Each drive's track loader issues block read/write requests as if it owned the port. The arbiter grants one drive at a time, round-robin, and routes ack, buffer strobes and buffer data to and from the granted drive only.
- Sits in the clk_sys domain between the drive instances and the HPS SD interface.

---
 rtl/c1571_pkg.sv | 17 +
 rtl/c1571_sd_arbiter_if.sv | 23 ++
 rtl/c1571_sd_arbiter_rr_pick.sv | 35 +++
 rtl/c1571_sd_arbiter.sv | 179 +++++++++++++++++
 tb/tb_c1571_sd_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/c1571_pkg.sv
// rtl/c1571_pkg.sv - shared types and constants for the c1571 SD block-port arbiter
package c1571_pkg;

    localparam int MAX_DRIVES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/c1571_sd_arbiter_if.sv
// rtl/c1571_sd_arbiter_if.sv - host-side SD block port shared by all drives
interface c1571_sd_arbiter_if;

    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    // Arbiter side: issues block requests and supplies write data
    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_wr
    );

    // Host side: acknowledges transfers and strobes the buffer
    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_wr
    );

endinterface

// File: rtl/c1571_sd_arbiter_rr_pick.sv
// rtl/c1571_sd_arbiter_rr_pick.sv - combinational round-robin first-set-bit finder
module rr_pick
    import c1571_pkg::*;
#(
    parameter int N = MAX_DRIVES
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [1:0]   idx,
    output logic         valid
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] rot;

    assign dbl = {req, req};
    assign rot = dbl >> ptr;

    // Scan the rotated vector so bit 0 is the pointer position; first hit wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                if (int'(ptr) + k >= N) begin
                    idx = 2'(int'(ptr) + k - N);
                end else begin
                    idx = 2'(int'(ptr) + k);
                end
            end
        end
    end

endmodule

// File: rtl/c1571_sd_arbiter.sv
// rtl/c1571_sd_arbiter.sv - round-robin share of one SD block port between drives (option: SD_ARB_TIMEOUT_EN)
module c1571_sd_arbiter
    import c1571_pkg::*;
#(
    parameter int          NDRIVES        = 4,
    parameter int          GRANT_GAP      = 1,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [32*NDRIVES-1:0]  drv_lba,
    input  logic [NDRIVES-1:0]     drv_rd,
    input  logic [NDRIVES-1:0]     drv_wr,
    output logic [NDRIVES-1:0]     drv_ack,
    output logic [NDRIVES-1:0]     drv_buff_wr,
    input  logic [8*NDRIVES-1:0]   drv_buff_din,
    output logic [NDRIVES-1:0]     drv_err,
    c1571_sd_arbiter_if.master     sd,
    output logic                   busy,
    output logic [1:0]             owner
);

    localparam int GAP_W = (GRANT_GAP > 0) ? $clog2(GRANT_GAP + 1) : 1;

    arb_state_t        state, state_n;
    logic [1:0]        rr_ptr, rr_ptr_n;
    logic [1:0]        own_r, own_n;
    logic [31:0]       lba_r, lba_n;
    logic              rd_r, rd_n;
    logic              wr_r, wr_n;
    logic [GAP_W-1:0]  gap_r, gap_n;
    logic              ack_q;

    logic [NDRIVES-1:0] pend;
    logic [1:0]         pick_idx;
    logic               pick_valid;
    logic               own_pend;
    logic [1:0]         own_next;
    logic               to_hit;
    op_t                op_sel;

    assign pend     = drv_rd | drv_wr;
    assign own_pend = drv_rd[own_r] | drv_wr[own_r];
    assign own_next = (own_r == 2'(NDRIVES - 1)) ? 2'd0 : own_r + 2'd1;

    rr_pick #(.N(NDRIVES)) u_rr_pick (
        .req   (pend),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef SD_ARB_TIMEOUT_EN
    logic [31:0]        to_cnt;
    logic [NDRIVES-1:0] err_q;
    logic [NDRIVES-1:0] own_onehot;

    assign to_hit = (state != IDLE) && (to_cnt == TIMEOUT_CYCLES - 32'd1);

    // One-hot of the current owner, used to steer the timeout pulse
    always_comb begin
        own_onehot        = '0;
        own_onehot[own_r] = 1'b1;
    end

    // Watchdog counts cycles spent in one busy state; any state change restarts it
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
            err_q  <= '0;
        end else begin
            if (state == IDLE || state_n != state) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 32'd1;
            end
            err_q <= to_hit ? own_onehot : '0;
        end
    end

    assign drv_err = err_q;
`else
    assign to_hit  = 1'b0;
    assign drv_err = '0;
`endif

    // State and datapath registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            own_r  <= '0;
            lba_r  <= '0;
            rd_r   <= 1'b0;
            wr_r   <= 1'b0;
            gap_r  <= '0;
            ack_q  <= 1'b0;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_ptr_n;
            own_r  <= own_n;
            lba_r  <= lba_n;
            rd_r   <= rd_n;
            wr_r   <= wr_n;
            gap_r  <= gap_n;
            ack_q  <= sd.sd_ack;
        end
    end

    // Next-state: grant in IDLE, wait for ack or withdrawal in REQ, wait for ack fall in XFER
    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        own_n    = own_r;
        lba_n    = lba_r;
        rd_n     = rd_r;
        wr_n     = wr_r;
        gap_n    = gap_r;
        op_sel   = drv_wr[pick_idx] ? OP_WR : OP_RD;
        unique case (state)
            IDLE: begin
                if (gap_r != '0) begin
                    gap_n = gap_r - 1'b1;
                end else if (pick_valid) begin
                    own_n   = pick_idx;
                    lba_n   = drv_lba[32*pick_idx +: 32];
                    rd_n    = (op_sel == OP_RD);
                    wr_n    = (op_sel == OP_WR);
                    state_n = REQ;
                end
            end
            REQ: begin
                if (to_hit) begin
                    rd_n     = 1'b0;
                    wr_n     = 1'b0;
                    rr_ptr_n = own_next;
                    state_n  = IDLE;
                end else if (sd.sd_ack) begin
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    state_n = XFER;
                end else if (!own_pend) begin
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    state_n = IDLE;
                end
            end
            XFER: begin
                if (to_hit) begin
                    rr_ptr_n = own_next;
                    state_n  = IDLE;
                end else if (ack_q && !sd.sd_ack) begin
                    rr_ptr_n = own_next;
                    gap_n    = GAP_W'(GRANT_GAP);
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output routing: everything zero while idle, drive-side strobes only during XFER
    always_comb begin
        drv_ack     = '0;
        drv_buff_wr = '0;
        if (state == XFER) begin
            drv_ack[own_r]     = sd.sd_ack;
            drv_buff_wr[own_r] = sd.sd_buff_wr;
        end
    end

    assign busy           = (state != IDLE);
    assign owner          = busy ? own_r : 2'd0;
    assign sd.sd_lba      = busy ? lba_r : 32'd0;
    assign sd.sd_rd       = rd_r;
    assign sd.sd_wr       = wr_r;
    assign sd.sd_buff_din = busy ? drv_buff_din[8*own_r +: 8] : 8'd0;

endmodule

// File: tb/tb_c1571_sd_arbiter.sv
// tb/tb_c1571_sd_arbiter.sv - scoreboard bench for c1571_sd_arbiter
module tb_c1571_sd_arbiter;
    import c1571_pkg::*;

    localparam int N   = 4;
    localparam int GAP = 1;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    logic [32*N-1:0] drv_lba;
    logic [N-1:0]    drv_rd, drv_wr, drv_ack, drv_buff_wr, drv_err;
    logic [8*N-1:0]  drv_buff_din;
    logic            busy;
    logic [1:0]      owner;

    c1571_sd_arbiter_if sd_bus();

    c1571_sd_arbiter #(
        .NDRIVES   (N),
        .GRANT_GAP (GAP)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .drv_lba      (drv_lba),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_ack      (drv_ack),
        .drv_buff_wr  (drv_buff_wr),
        .drv_buff_din (drv_buff_din),
        .drv_err      (drv_err),
        .sd           (sd_bus),
        .busy         (busy),
        .owner        (owner)
    );

    typedef struct {
        logic [1:0]  own;
        logic        wr;
        logic [31:0] lba;
        logic [7:0]  din;
    } grant_t;

    grant_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic request(input int d, input logic rd, input logic wr,
                           input logic [31:0] lba, input logic [7:0] din);
        grant_t g;
        drv_lba[32*d +: 32] = lba;
        drv_buff_din[8*d +: 8] = din;
        drv_rd[d] = rd;
        drv_wr[d] = wr;
        g.own = 2'(d);
        g.wr  = wr;
        g.lba = lba;
        g.din = din;
        sb.push_back(g);
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (sd_bus.sd_rd || sd_bus.sd_wr) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
    endtask

    task automatic serve(input int beats);
        bit     ok;
        grant_t g;
        int     o;
        wait_strobe(ok);
        check_eq("grant_seen", 32'(ok), 32'd1);
        if (!ok) return;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd0, 32'd1);
            return;
        end
        g = sb.pop_front();
        o = int'(g.own);
        check_eq("owner", 32'(owner), 32'(g.own));
        check_eq("sd_lba", sd_bus.sd_lba, g.lba);
        check_eq("sd_wr", 32'(sd_bus.sd_wr), 32'(g.wr));
        check_eq("sd_rd", 32'(sd_bus.sd_rd), 32'(!g.wr));
        sd_bus.sd_ack = 1'b1;
        @(negedge clk_sys);
        for (int b = 0; b < beats; b++) begin
            sd_bus.sd_buff_wr = (b % 2 == 1);
            #1;
            check_eq("drv_ack", 32'(drv_ack), 32'd1 << o);
            check_eq("drv_buff_wr", 32'(drv_buff_wr), 32'(sd_bus.sd_buff_wr) << o);
            check_eq("sd_buff_din", 32'(sd_bus.sd_buff_din), 32'(g.din));
            check_eq("lba_hold", sd_bus.sd_lba, g.lba);
            if (b == 0) begin
                drv_rd[o] = 1'b0;
                drv_wr[o] = 1'b0;
                drv_lba[32*o +: 32] = ~g.lba;
            end
            @(negedge clk_sys);
        end
        sd_bus.sd_ack     = 1'b0;
        sd_bus.sd_buff_wr = 1'b0;
        @(negedge clk_sys);
        #1;
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_din", 32'(sd_bus.sd_buff_din), 32'd0);
        check_eq("idle_lba", sd_bus.sd_lba, 32'd0);
        check_eq("idle_ack", 32'(drv_ack), 32'd0);
    endtask

    task automatic measure_gap();
        int n;
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_sys);
            #1;
            if (busy) break;
            n++;
        end
        check_eq("grant_gap", 32'(n), 32'(GAP + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset             = 1'b1;
        drv_lba           = '0;
        drv_rd            = '0;
        drv_wr            = '0;
        drv_buff_din      = '0;
        sd_bus.sd_ack     = 1'b0;
        sd_bus.sd_buff_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd", 32'(sd_bus.sd_rd), 32'd0);
        check_eq("rst_wr", 32'(sd_bus.sd_wr), 32'd0);
        check_eq("rst_lba", sd_bus.sd_lba, 32'd0);
        check_eq("rst_owner", 32'(owner), 32'd0);
        check_eq("rst_err", 32'(drv_err), 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;

        // spurious ack while idle
        @(negedge clk_sys);
        sd_bus.sd_ack     = 1'b1;
        sd_bus.sd_buff_wr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_sys);
            #1;
            check_eq("spur_ack", 32'(drv_ack), 32'd0);
            check_eq("spur_bwr", 32'(drv_buff_wr), 32'd0);
            check_eq("spur_busy", 32'(busy), 32'd0);
        end
        sd_bus.sd_ack     = 1'b0;
        sd_bus.sd_buff_wr = 1'b0;
        @(negedge clk_sys);

        // contention from pointer 0: grants 0, 1 (write, 0xA5 data), 3
        request(0, 1'b1, 1'b0, 32'h100, 8'h5A);
        request(1, 1'b0, 1'b1, 32'h200, 8'hA5);
        request(3, 1'b1, 1'b0, 32'h300, 8'h33);
        serve(8);
        measure_gap();
        serve(8);
        measure_gap();
        serve(8);
        repeat (3) @(negedge clk_sys);

        // withdrawal before ack
        drv_rd[0] = 1'b1;
        @(negedge clk_sys);
        #1;
        check_eq("wd_rd_up", 32'(sd_bus.sd_rd), 32'd1);
        check_eq("wd_owner", 32'(owner), 32'd0);
        drv_rd[0] = 1'b0;
        @(negedge clk_sys);
        #1;
        check_eq("wd_rd_down", 32'(sd_bus.sd_rd), 32'd0);
        check_eq("wd_busy", 32'(busy), 32'd0);
        @(negedge clk_sys);

        // pointer still 0: drive 0 before drive 2; drive 2 has rd+wr so write wins
        request(0, 1'b1, 1'b0, 32'h400, 8'h11);
        request(2, 1'b1, 1'b1, 32'h500, 8'h22);
        serve(4);
        serve(4);
        repeat (3) @(negedge clk_sys);

        // single read on drive 2, one-cycle latency, full 512-beat block
        request(2, 1'b1, 1'b0, 32'h123, 8'h00);
        @(negedge clk_sys);
        #1;
        check_eq("lat_rd", 32'(sd_bus.sd_rd), 32'd1);
        check_eq("lat_lba", sd_bus.sd_lba, 32'h123);
        serve(512);
        repeat (3) @(negedge clk_sys);

        // pointer now 3: drive 3 wins over drive 1
        request(3, 1'b1, 1'b0, 32'h700, 8'h77);
        request(1, 1'b1, 1'b0, 32'h600, 8'h66);
        serve(4);
        serve(4);
        repeat (3) @(negedge clk_sys);

        // asynchronous reset in the middle of a transfer
        drv_lba[64 +: 32] = 32'h800;
        drv_rd[2] = 1'b1;
        wait_strobe(ok);
        check_eq("mid_grant", 32'(ok), 32'd1);
        sd_bus.sd_ack = 1'b1;
        @(negedge clk_sys);
        #1;
        check_eq("mid_ack", 32'(drv_ack), 32'h4);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_rd", 32'(sd_bus.sd_rd), 32'd0);
        check_eq("arst_lba", sd_bus.sd_lba, 32'd0);
        check_eq("arst_owner", 32'(owner), 32'd0);
        check_eq("arst_ack", 32'(drv_ack), 32'd0);
        check_eq("arst_din", 32'(sd_bus.sd_buff_din), 32'd0);
        drv_rd[2]     = 1'b0;
        sd_bus.sd_ack = 1'b0;
        request(1, 1'b1, 1'b0, 32'h900, 8'h44);
        @(negedge clk_sys);
        reset = 1'b0;
        serve(4);
        repeat (3) @(negedge clk_sys);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        check_eq("no_err", 32'(drv_err), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
